// File: rtl/sync_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sync_transfer_scheduler
// Description : Round-robin scheduler that presents one requester word at a
//               time to an enable-based synchronizer (LOAD/HOLD/GAP framing).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_transfer_scheduler #(
    parameter int DATA_WIDTH  = 5,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          sync_en,
    output logic [DATA_WIDTH-1:0]         sync_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int c_ID_W    = $clog2(NUM_REQ);
    localparam int c_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_ID_W-1:0]  c_LAST_RST  = c_ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_ID_W-1:0]     r_last_grant;
    logic [c_ID_W-1:0]     r_grant_id;
    logic [c_ID_W-1:0]     w_grant;
    logic                  w_found;
    logic [NUM_REQ-1:0]    w_req_upper;
    logic [DATA_WIDTH-1:0] r_sync_data;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  r_sync_en;
    logic                  r_busy;
    logic [NUM_REQ-1:0]    r_ack;
    logic [NUM_REQ-1:0]    w_ack_nxt;

    // Round-robin: prefer requesters above the last grant, else wrap to the lowest.
    always_comb begin
        w_req_upper = '0;
        w_grant     = '0;
        w_word      = '0;
        w_found     = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_upper[i] = req[i] && (c_ID_W'(i) > r_last_grant);
        end
        if (|w_req_upper) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_req_upper[i]) begin
                    w_grant = c_ID_W'(i);
                end
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    w_grant = c_ID_W'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (c_ID_W'(i) == w_grant) begin
                w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
            end
            S_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Ack is registered alongside sync_en so it lands on the final HOLD cycle.
    always_comb begin
        w_ack_nxt = '0;
        if ((w_state_nxt == S_HOLD) && (w_cnt_nxt == c_HOLD_LAST)) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_ack_nxt[i] = (c_ID_W'(i) == r_grant_id);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_LAST_RST;
            r_grant_id   <= '0;
            r_sync_data  <= '0;
            r_sync_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_ack        <= '0;
        end else begin
            r_sync_en <= (w_state_nxt == S_HOLD);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_ack     <= w_ack_nxt;
            if ((r_state == S_IDLE) && w_found) begin
                r_grant_id   <= w_grant;
                r_last_grant <= w_grant;
                r_sync_data  <= w_word;
            end
        end
    end

    assign ack       = r_ack;
    assign sync_en   = r_sync_en;
    assign sync_data = r_sync_data;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/sync_transfer_scheduler.md
SYNC_TRANSFER_SCHEDULER -- requirements
Module: sync_transfer_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
  - DATA_WIDTH, default 5, width of each transferred word.
  - NUM_REQ, default 4, number of requesters; legal range >=2.
  - HOLD_CYCLES, default 3, cycles sync_en stays high per transfer; legal range >=1.
  - GAP_CYCLES, default 2, idle cycles after each transfer; legal range >=0.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
  - clk  in  1  source-domain clock; all logic on rising edge.
  - rst  in  1  synchronous active-high reset.
  - req  in  NUM_REQ  per-requester transfer request, level.
  - req_data  in  NUM_REQ*DATA_WIDTH  word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
  - ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
  - sync_en  out  1  enable to the downstream enable-based synchronizer.
  - sync_data  out  DATA_WIDTH  registered word to the synchronizer data input.
  - grant_id  out  clog2(NUM_REQ)  index of the current or last grant.
  - busy  out  1  high in every state except IDLE.

Function
REQ-004 FSM SHALL have four states: IDLE, LOAD, HOLD, GAP.
REQ-005 IDLE, any req bit high: round-robin grant searching from last_grant+1 upward with wrap; next state LOAD.
REQ-006 IDLE, req all zero: remain in IDLE with sync_en=0.
REQ-007 On the IDLE->LOAD edge:
  - sync_data SHALL load the granted word.
  - grant_id SHALL load the granted index.
  - last_grant SHALL update to the granted index.
REQ-008 LOAD SHALL last exactly one cycle with sync_en=0, so data is stable one cycle before enable; next state HOLD.
REQ-009 HOLD SHALL last exactly HOLD_CYCLES cycles with sync_en=1.
REQ-010 ack[grant_id] SHALL be high only in the last HOLD cycle; all other ack bits stay 0.
REQ-011 GAP SHALL last GAP_CYCLES cycles with sync_en=0; when GAP_CYCLES=0, HOLD SHALL go directly to IDLE.
REQ-012 sync_data and grant_id SHALL hold their values from LOAD until the next grant; req_data changes outside IDLE are ignored.
REQ-013 Deassertion of req[grant_id] after grant SHALL NOT abort the transfer; ack still pulses.
REQ-014 A req held high after its ack SHALL be treated as a new request at the next IDLE.
REQ-015 Latency, req sampled in IDLE at cycle N:
  - LOAD at N+1.
  - sync_en high N+2..N+1+HOLD_CYCLES.
  - ack at N+1+HOLD_CYCLES.
  - IDLE at N+2+HOLD_CYCLES+GAP_CYCLES.
  - Minimum grant-to-grant period is HOLD_CYCLES+GAP_CYCLES+2 (7 at defaults).
REQ-016 sync_en SHALL never be high in IDLE, LOAD or GAP.
REQ-017 sync_data SHALL never change while sync_en=1.
REQ-018 Round-robin wrap: after grant NUM_REQ-1, the search SHALL start at index 0.

Reset
REQ-019 While rst=1 at a rising edge, the next state SHALL be:
  - state=IDLE, last_grant=NUM_REQ-1.
  - sync_en=0, ack=0, busy=0, sync_data=0, grant_id=0.
REQ-020 rst asserted in any state, including mid-HOLD, SHALL take effect at that edge with no ack pulse; the in-flight transfer is discarded.
REQ-021 After reset, the first arbitration SHALL give requester 0 highest priority.

Verification (defaults DATA_WIDTH=5, NUM_REQ=4, HOLD=3, GAP=2)
REQ-022 req=4'b0010, word1=5'h15 sampled at cycle 0:
  - grant_id=1 and sync_data=5'h15 at cycle 1.
  - sync_en=1 cycles 2-4.
  - ack=4'b0010 cycle 4 only.
  - busy cycles 1-6; IDLE at cycle 7.
REQ-023 req=4'b1111 held continuously from reset: grants SHALL be 0,1,2,3,0 starting 7 cycles apart; each ack goes only to its grantee.
REQ-024 last_grant=2, req=4'b1100: grant SHALL be 3, then next grant 2.
REQ-025 req[0] dropped and word0 changed 5'h0A->5'h1F during HOLD: sync_data SHALL stay 5'h0A and ack[0] SHALL still pulse.
REQ-026 rst=1 during second HOLD cycle:
  - Next cycle sync_en=0, busy=0, sync_data=0, and no ack.
  - After release with req=4'b1001, grant SHALL be 0.
REQ-027 GAP_CYCLES=0 with req=4'b0001 held: sync_en SHALL go high for 3 cycles every 5 cycles, low for 2.
